penalty_referee: RTL and testbench

Match-control stage downstream of the ball trajectory block. It watches the ball's vertical position and registered save flag to detect each resolved penalty, then scores it. It alternates the shooting team, holds a result banner, and applies best-of-`ROUNDS` rules with sudden death. Its `input_enable` output gates the shooter and keeper keycodes feeding the ball block, and its score and banner outputs drive the HUD sprite logic.

---
 rtl/penalty_referee.sv | 219 +++++++++++++++++++++
 tb/tb_penalty_referee.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/penalty_referee.sv
`default_nettype none
// ============================================================================
// Module      : penalty_referee
// Description : Match control for a penalty shoot-out. It watches the ball Y
//               position and the registered save flag to detect each resolved
//               shot and scores it. It alternates the shooter, holds a result
//               banner, and applies best-of-ROUNDS rules with sudden death.
// Ports       : frame_clk/Reset   - frame clock, synchronous active-high reset
//               keycode           - raw keyboard code (Enter starts a match)
//               BallY             - ball Y position from the ball block
//               save_detected     - registered save flag from the ball block
//               input_enable      - lets shooter/keeper keys reach the ball
//               shooter_team      - 0 = team A shooting, 1 = team B
//               score_a/score_b   - goals per team (saturating)
//               kicks_a/kicks_b   - kicks per team (saturating)
//               last_result       - 00 none, 01 goal, 10 save
//               banner_active     - result banner hold in progress
//               game_over, winner - match decided; 01 A, 10 B, 11 draw
// Revision    : 1.0 - initial release
// ============================================================================
module penalty_referee #(
  parameter int         ROUNDS      = 5,
  parameter int         BALL_Y_HOME = 365,
  parameter int         Y_MID       = 200,
  parameter int         RESULT_HOLD = 120,
  parameter logic [7:0] KEY_START   = 8'h28
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [9:0] BallY,
  input  logic       save_detected,
  output logic       input_enable,
  output logic       shooter_team,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic [3:0] kicks_a,
  output logic [3:0] kicks_b,
  output logic [1:0] last_result,
  output logic       banner_active,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int                  c_HOLD_W    = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(RESULT_HOLD - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
  localparam logic [9:0]          c_HOME      = 10'(BALL_Y_HOME);
  localparam logic [9:0]          c_MID       = 10'(Y_MID);
  localparam logic [4:0]          c_ROUNDS    = 5'(ROUNDS);

  typedef enum logic [1:0] {
    S_READY       = 2'd0,
    S_IN_PLAY     = 2'd1,
    S_SHOW_RESULT = 2'd2,
    S_GAME_OVER   = 2'd3
  } state_t;

  state_t              r_state, w_state_next;
  logic [9:0]          r_ball_q;
  logic [7:0]          r_key_q;
  logic [c_HOLD_W-1:0] r_hold, w_hold_next;
  logic                r_shooter, w_shooter_next;
  logic [3:0]          r_score_a, w_score_a_next;
  logic [3:0]          r_score_b, w_score_b_next;
  logic [3:0]          r_kicks_a, w_kicks_a_next;
  logic [3:0]          r_kicks_b, w_kicks_b_next;
  logic [1:0]          r_last, w_last_next;
  logic [1:0]          r_winner, w_winner_next;
  logic                r_input_en, r_banner, r_over;

  logic                w_start, w_resolved;
  logic [4:0]          w_sa, w_sb, w_ka, w_kb, w_rem_a, w_rem_b;
  logic [1:0]          w_verdict;

  function automatic logic [3:0] f_sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Edge-detect Enter so a held key starts exactly one match.
  assign w_start    = (keycode == KEY_START) && (r_key_q != KEY_START);
  // A shot has resolved when the ball snaps home from high up the screen.
  assign w_resolved = (r_ball_q < c_MID) && (BallY == c_HOME);

  // Decision on the registered counts, in 5 bits so sums never wrap.
  always_comb begin
    w_sa      = {1'b0, r_score_a};
    w_sb      = {1'b0, r_score_b};
    w_ka      = {1'b0, r_kicks_a};
    w_kb      = {1'b0, r_kicks_b};
    w_rem_a   = (w_ka >= c_ROUNDS) ? 5'd0 : c_ROUNDS - w_ka;
    w_rem_b   = (w_kb >= c_ROUNDS) ? 5'd0 : c_ROUNDS - w_kb;
    w_verdict = 2'b00;
    if ((w_ka < c_ROUNDS) || (w_kb < c_ROUNDS)) begin
      if (w_sa > w_sb + w_rem_b) begin
        w_verdict = 2'b01;
      end else if (w_sb > w_sa + w_rem_a) begin
        w_verdict = 2'b10;
      end
    end else if (w_ka == w_kb) begin
      // Sudden death is only judged once both teams have kicked equally.
      if (w_sa > w_sb) begin
        w_verdict = 2'b01;
      end else if (w_sb > w_sa) begin
        w_verdict = 2'b10;
      end else if (w_ka == 5'd15) begin
        w_verdict = 2'b11;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_hold_next    = r_hold;
    w_shooter_next = r_shooter;
    w_score_a_next = r_score_a;
    w_score_b_next = r_score_b;
    w_kicks_a_next = r_kicks_a;
    w_kicks_b_next = r_kicks_b;
    w_last_next    = r_last;
    w_winner_next  = r_winner;
    case (r_state)
      S_READY: begin
        if (w_start) begin
          w_state_next   = S_IN_PLAY;
          w_shooter_next = 1'b0;
          w_score_a_next = 4'd0;
          w_score_b_next = 4'd0;
          w_kicks_a_next = 4'd0;
          w_kicks_b_next = 4'd0;
        end
      end
      S_IN_PLAY: begin
        if (w_resolved) begin
          if (!r_shooter) begin
            w_kicks_a_next = f_sat_inc(r_kicks_a);
            if (!save_detected) w_score_a_next = f_sat_inc(r_score_a);
          end else begin
            w_kicks_b_next = f_sat_inc(r_kicks_b);
            if (!save_detected) w_score_b_next = f_sat_inc(r_score_b);
          end
          w_last_next  = save_detected ? 2'b10 : 2'b01;
          w_hold_next  = c_HOLD_LOAD;
          w_state_next = S_SHOW_RESULT;
        end
      end
      S_SHOW_RESULT: begin
        if (r_hold == '0) begin
          if (w_verdict != 2'b00) begin
            w_winner_next = w_verdict;
            w_state_next  = S_GAME_OVER;
          end else begin
            w_shooter_next = ~r_shooter;
            w_state_next   = S_IN_PLAY;
          end
        end else begin
          w_hold_next = r_hold - c_HOLD_ONE;
        end
      end
      S_GAME_OVER: begin
        if (w_start) begin
          w_winner_next = 2'b00;
          w_last_next   = 2'b00;
          w_state_next  = S_READY;
        end
      end
      default: w_state_next = S_READY;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state    <= S_READY;
      r_ball_q   <= c_HOME;
      r_key_q    <= 8'd0;
      r_hold     <= '0;
      r_shooter  <= 1'b0;
      r_score_a  <= 4'd0;
      r_score_b  <= 4'd0;
      r_kicks_a  <= 4'd0;
      r_kicks_b  <= 4'd0;
      r_last     <= 2'b00;
      r_winner   <= 2'b00;
      r_input_en <= 1'b0;
      r_banner   <= 1'b0;
      r_over     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ball_q   <= BallY;
      r_key_q    <= keycode;
      r_hold     <= w_hold_next;
      r_shooter  <= w_shooter_next;
      r_score_a  <= w_score_a_next;
      r_score_b  <= w_score_b_next;
      r_kicks_a  <= w_kicks_a_next;
      r_kicks_b  <= w_kicks_b_next;
      r_last     <= w_last_next;
      r_winner   <= w_winner_next;
      // State-decoded outputs are registered from the next state so they
      // line up with the state register.
      r_input_en <= (w_state_next == S_IN_PLAY);
      r_banner   <= (w_state_next == S_SHOW_RESULT);
      r_over     <= (w_state_next == S_GAME_OVER);
    end
  end

  assign input_enable  = r_input_en;
  assign shooter_team  = r_shooter;
  assign score_a       = r_score_a;
  assign score_b       = r_score_b;
  assign kicks_a       = r_kicks_a;
  assign kicks_b       = r_kicks_b;
  assign last_result   = r_last;
  assign banner_active = r_banner;
  assign game_over     = r_over;
  assign winner        = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_penalty_referee.sv
`default_nettype none
// ============================================================================
// Module      : tb_penalty_referee
// Description : Directed self-checking bench for penalty_referee. Expected
//               output snapshots are queued as stimulus is applied and popped
//               when the DUT reaches the matching point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_penalty_referee;

  localparam int         RH    = 120;
  localparam logic [7:0] ENTER = 8'h28;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] keycode = 8'd0;
  logic [9:0] BallY = 10'd365;
  logic       save_detected = 1'b0;
  logic       input_enable, shooter_team, banner_active, game_over;
  logic [3:0] score_a, score_b, kicks_a, kicks_b;
  logic [1:0] last_result, winner;

  penalty_referee dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .BallY         (BallY),
    .save_detected (save_detected),
    .input_enable  (input_enable),
    .shooter_team  (shooter_team),
    .score_a       (score_a),
    .score_b       (score_b),
    .kicks_a       (kicks_a),
    .kicks_b       (kicks_b),
    .last_result   (last_result),
    .banner_active (banner_active),
    .game_over     (game_over),
    .winner        (winner)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model of the match state
  int         m_sa, m_sb, m_ka, m_kb;
  logic       m_sh;
  logic [1:0] m_lr, m_win;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%0d expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic expect_status(input logic ie, input logic sh, input int sa, input int sbv,
                               input int ka, input int kb, input logic [1:0] lr,
                               input logic ban, input logic go, input logic [1:0] win);
    push("input_enable", 32'(ie));
    push("shooter_team", 32'(sh));
    push("score_a", 32'(sa));
    push("score_b", 32'(sbv));
    push("kicks_a", 32'(ka));
    push("kicks_b", 32'(kb));
    push("last_result", 32'(lr));
    push("banner_active", 32'(ban));
    push("game_over", 32'(go));
    push("winner", 32'(win));
  endtask

  task automatic compare_status();
    pop_chk(32'(input_enable));
    pop_chk(32'(shooter_team));
    pop_chk(32'(score_a));
    pop_chk(32'(score_b));
    pop_chk(32'(kicks_a));
    pop_chk(32'(kicks_b));
    pop_chk(32'(last_result));
    pop_chk(32'(banner_active));
    pop_chk(32'(game_over));
    pop_chk(32'(winner));
  endtask

  task automatic expect_reset_values();
    expect_status(1'b0, 1'b0, 0, 0, 0, 0, 2'b00, 1'b0, 1'b0, 2'b00);
  endtask

  // Flight up the screen; ends with the ball just returned home (not yet clocked).
  task automatic sweep(input logic save);
    BallY = 10'd300; tick();
    BallY = 10'd150; tick();
    BallY = 10'd108; tick();
    BallY = 10'd365;
    save_detected = save;
  endtask

  // One complete kick: resolution, banner hold, then next shooter or verdict.
  task automatic shoot(input logic save, input logic [1:0] exp_win);
    int frames;
    if (!m_sh) begin
      m_ka++;
      if (!save) m_sa++;
    end else begin
      m_kb++;
      if (!save) m_sb++;
    end
    m_lr = save ? 2'b10 : 2'b01;
    expect_status(1'b0, m_sh, m_sa, m_sb, m_ka, m_kb, m_lr, 1'b1, 1'b0, 2'b00);
    push("hold_frames", 32'(RH));
    if (exp_win != 2'b00) begin
      expect_status(1'b0, m_sh, m_sa, m_sb, m_ka, m_kb, m_lr, 1'b0, 1'b1, exp_win);
      m_win = exp_win;
    end else begin
      expect_status(1'b1, ~m_sh, m_sa, m_sb, m_ka, m_kb, m_lr, 1'b0, 1'b0, 2'b00);
    end
    sweep(save);
    tick();
    compare_status();
    frames = 0;
    while (banner_active === 1'b1 && frames < RH + 8) begin
      frames++;
      tick();
    end
    pop_chk(32'(frames));
    compare_status();
    if (exp_win == 2'b00) m_sh = ~m_sh;
    save_detected = 1'b0;
  endtask

  task automatic model_clear();
    m_sa = 0; m_sb = 0; m_ka = 0; m_kb = 0;
    m_sh = 1'b0; m_lr = 2'b00; m_win = 2'b00;
  endtask

  // GAME_OVER -> READY on one Enter press, then READY -> IN_PLAY on the next.
  task automatic restart_from_game_over();
    keycode = ENTER;
    m_lr = 2'b00; m_win = 2'b00;
    expect_status(1'b0, m_sh, m_sa, m_sb, m_ka, m_kb, 2'b00, 1'b0, 1'b0, 2'b00);
    tick();
    compare_status();
    keycode = 8'd0; tick();
    keycode = ENTER;
    model_clear();
    expect_status(1'b1, 1'b0, 0, 0, 0, 0, 2'b00, 1'b0, 1'b0, 2'b00);
    tick();
    compare_status();
    keycode = 8'd0; tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();

    // ---- Reset state
    Reset = 1'b1;
    expect_reset_values();
    tick(); tick();
    compare_status();
    Reset = 1'b0;
    tick();

    // ---- Enter held for 10 frames: keycode presented just after edge N,
    //      input_enable must be up after edge N+1, and stays in play.
    keycode = ENTER;
    expect_status(1'b1, 1'b0, 0, 0, 0, 0, 2'b00, 1'b0, 1'b0, 2'b00);
    tick();
    compare_status();
    expect_status(1'b1, 1'b0, 0, 0, 0, 0, 2'b00, 1'b0, 1'b0, 2'b00);
    repeat (9) tick();
    compare_status();
    keycode = 8'd0;
    tick();

    // ---- Returns from Y >= Y_MID never resolve (250, and the 200 boundary)
    BallY = 10'd250; tick();
    BallY = 10'd365; tick(); tick();
    BallY = 10'd200; tick();
    BallY = 10'd365;
    expect_status(1'b1, 1'b0, 0, 0, 0, 0, 2'b00, 1'b0, 1'b0, 2'b00);
    tick(); tick();
    compare_status();

    // ---- Goal for A, save against B, then early finish at 3-0 after 3 each
    shoot(1'b0, 2'b00);
    shoot(1'b1, 2'b00);
    shoot(1'b0, 2'b00);
    shoot(1'b1, 2'b00);
    shoot(1'b0, 2'b00);
    shoot(1'b1, 2'b01);

    // ---- Frozen in GAME_OVER: a resolving sweep changes nothing
    expect_status(1'b0, m_sh, m_sa, m_sb, m_ka, m_kb, m_lr, 1'b0, 1'b1, m_win);
    sweep(1'b0);
    tick(); tick();
    compare_status();

    // ---- Sudden death: 4-4 after five each, A scores and B is saved in round 6
    restart_from_game_over();
    repeat (4) begin
      shoot(1'b0, 2'b00);
      shoot(1'b0, 2'b00);
    end
    shoot(1'b1, 2'b00);
    shoot(1'b1, 2'b00);
    shoot(1'b0, 2'b00);
    shoot(1'b1, 2'b01);
    push("final_score_a", 32'd5);
    push("final_score_b", 32'd4);
    push("final_kicks_a", 32'd6);
    push("final_kicks_b", 32'd6);
    pop_chk(32'(score_a));
    pop_chk(32'(score_b));
    pop_chk(32'(kicks_a));
    pop_chk(32'(kicks_b));

    // ---- Reset midway through the result hold
    restart_from_game_over();
    expect_status(1'b0, 1'b0, 1, 0, 1, 0, 2'b01, 1'b1, 1'b0, 2'b00);
    sweep(1'b0);
    tick();
    repeat (50) tick();
    compare_status();
    save_detected = 1'b0;
    Reset = 1'b1;
    expect_reset_values();
    tick();
    compare_status();
    Reset = 1'b0;

    // ---- A resolving-looking return while in READY is ignored
    BallY = 10'd100; tick();
    BallY = 10'd365;
    expect_reset_values();
    tick(); tick();
    compare_status();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
